// File: rtl/flash_arbiter.sv
// Program-flash arbiter: instruction fetch vs LPM data port.
// Fetch has priority; a saturating starvation counter forces LPM through.
module flash_arbiter #(
  parameter int flash_width  = 10,
  parameter int starve_limit = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [flash_width-1:0] if_a,
  output logic                   if_gnt,
  output logic                   if_valid,
  output logic [15:0]            if_d,
  input  logic                   lpm_req,
  input  logic [flash_width:0]   lpm_a,
  output logic                   lpm_gnt,
  output logic                   lpm_valid,
  output logic [7:0]             lpm_d,
  output logic                   mem_ce,
  output logic [flash_width-1:0] mem_a,
  input  logic [15:0]            mem_d
);

  localparam int CW = $clog2(starve_limit + 1);
  localparam logic [CW-1:0] LIMIT = CW'(starve_limit);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          tag_if_q, tag_if_d;
  logic          tag_lpm_q, tag_lpm_d;
  logic          tag_hi_q, tag_hi_d;
  logic          force_lpm;

  assign force_lpm = (starve_cnt_q == LIMIT);

  always_comb begin
    if_gnt  = 1'b0;
    lpm_gnt = 1'b0;
    // Grants are held off while reset is asserted
    if (!rst) begin
      if (if_req && !(lpm_req && force_lpm)) begin
        if_gnt = 1'b1;
      end else if (lpm_req) begin
        lpm_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_a = '0;
    if (if_gnt) begin
      mem_a = if_a;
    end else if (lpm_gnt) begin
      mem_a = lpm_a[flash_width:1];
    end
  end

  assign mem_ce = if_gnt | lpm_gnt;

  always_comb begin
    starve_cnt_d = '0;
    if (lpm_req && !lpm_gnt) begin
      starve_cnt_d = force_lpm ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  always_comb begin
    tag_if_d  = if_gnt;
    tag_lpm_d = lpm_gnt;
    tag_hi_d  = tag_hi_q;
    if (lpm_gnt) begin
      tag_hi_d = lpm_a[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      tag_if_q     <= 1'b0;
      tag_lpm_q    <= 1'b0;
      tag_hi_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_if_q     <= tag_if_d;
      tag_lpm_q    <= tag_lpm_d;
      tag_hi_q     <= tag_hi_d;
    end
  end

  assign if_valid  = tag_if_q;
  assign lpm_valid = tag_lpm_q;
  assign if_d      = mem_d;
  // Little-endian: odd byte address takes the high byte
  assign lpm_d     = tag_hi_q ? mem_d[15:8] : mem_d[7:0];

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a one-cycle flash model.
// Covers reset, byte select, starvation bound and withdrawn requests.
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [9:0]  if_a = '0;
  logic        lpm_req = 1'b0;
  logic [10:0] lpm_a = '0;
  logic        if_gnt, if_valid, lpm_gnt, lpm_valid, mem_ce;
  logic [15:0] if_d;
  logic [7:0]  lpm_d;
  logic [9:0]  mem_a;
  logic [15:0] mem_d = '0;

  logic        if_gnt1, if_valid1, lpm_gnt1, lpm_valid1, mem_ce1;
  logic [15:0] if_d1;
  logic [7:0]  lpm_d1;
  logic [9:0]  mem_a1;

  logic [15:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flash_arbiter #(.flash_width(10), .starve_limit(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_a(if_a), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_d(if_d),
    .lpm_req(lpm_req), .lpm_a(lpm_a), .lpm_gnt(lpm_gnt),
    .lpm_valid(lpm_valid), .lpm_d(lpm_d),
    .mem_ce(mem_ce), .mem_a(mem_a), .mem_d(mem_d)
  );

  flash_arbiter #(.flash_width(10), .starve_limit(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_a(if_a), .if_gnt(if_gnt1),
    .if_valid(if_valid1), .if_d(if_d1),
    .lpm_req(lpm_req), .lpm_a(lpm_a), .lpm_gnt(lpm_gnt1),
    .lpm_valid(lpm_valid1), .lpm_d(lpm_d1),
    .mem_ce(mem_ce1), .mem_a(mem_a1), .mem_d(mem_d)
  );

  always @(posedge clk) begin
    if (mem_ce) mem_d <= mem[mem_a];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [9:0]  if_a;
    logic        lpm_req;
    logic [10:0] lpm_a;
    logic        e_if_gnt;
    logic        e_lpm_gnt;
    logic [9:0]  e_mem_a;
    logic        e_if_valid;
    logic [15:0] e_if_d;
    logic        e_lpm_valid;
    logic [7:0]  e_lpm_d;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic       pif, plpm, el, el1;
    logic [9:0] pa, fa;

    for (int i = 0; i < 1024; i++) mem[i] = 16'h5000 + 16'(i);
    mem[10'h012] = 16'hBEEF;

    vt[0] = '{1'b0, 10'h000, 1'b1, 11'h025, 1'b0, 1'b1, 10'h012,
              1'b0, 16'h0000, 1'b0, 8'h00};
    vt[1] = '{1'b0, 10'h000, 1'b1, 11'h024, 1'b0, 1'b1, 10'h012,
              1'b0, 16'h0000, 1'b1, 8'h12};
    vt[2] = '{1'b1, 10'h100, 1'b0, 11'h000, 1'b1, 1'b0, 10'h100,
              1'b0, 16'h0000, 1'b1, 8'h34};
    vt[3] = '{1'b0, 10'h000, 1'b0, 11'h000, 1'b0, 1'b0, 10'h000,
              1'b1, 16'h5100, 1'b0, 8'h00};
    vt[4] = '{1'b0, 10'h000, 1'b1, 11'h201, 1'b0, 1'b1, 10'h100,
              1'b0, 16'h0000, 1'b0, 8'h00};
    vt[5] = '{1'b0, 10'h000, 1'b1, 11'h200, 1'b0, 1'b1, 10'h100,
              1'b0, 16'h0000, 1'b1, 8'h51};
    vt[6] = '{1'b1, 10'h3FF, 1'b0, 11'h000, 1'b1, 1'b0, 10'h3FF,
              1'b0, 16'h0000, 1'b1, 8'h00};
    vt[7] = '{1'b1, 10'h001, 1'b1, 11'h0AB, 1'b1, 1'b0, 10'h001,
              1'b1, 16'h53FF, 1'b0, 8'h00};
    vt[8] = '{1'b0, 10'h000, 1'b0, 11'h000, 1'b0, 1'b0, 10'h000,
              1'b1, 16'h5001, 1'b0, 8'h00};
    vt[9] = '{1'b0, 10'h000, 1'b0, 11'h000, 1'b0, 1'b0, 10'h000,
              1'b0, 16'h0000, 1'b0, 8'h00};

    // Reset held with both requesters active
    if_req = 1'b1; if_a = 10'h155;
    lpm_req = 1'b1; lpm_a = 11'h2AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_if_gnt", 32'(if_gnt), 0);
      chk("rst_lpm_gnt", 32'(lpm_gnt), 0);
      chk("rst_mem_ce", 32'(mem_ce), 0);
      chk("rst_mem_a", 32'(mem_a), 0);
      chk("rst_if_valid", 32'(if_valid), 0);
      chk("rst_lpm_valid", 32'(lpm_valid), 0);
    end

    // Single fetch in the first cycle after reset
    #1;
    rst = 1'b0;
    if_req = 1'b1; if_a = 10'h012; lpm_req = 1'b0;
    #1;
    chk("fetch_gnt", 32'(if_gnt), 1);
    chk("fetch_ce", 32'(mem_ce), 1);
    chk("fetch_mem_a", 32'(mem_a), 32'h012);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_valid", 32'(if_valid), 1);
    chk("fetch_d", 32'(if_d), 32'hBEEF);
    mem[10'h012] = 16'h1234;
    @(posedge clk); #1;

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      if_req = vt[i].if_req; if_a = vt[i].if_a;
      lpm_req = vt[i].lpm_req; lpm_a = vt[i].lpm_a;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vt[i].e_if_gnt));
      chk($sformatf("v%0d_lpm_gnt", i), 32'(lpm_gnt), 32'(vt[i].e_lpm_gnt));
      chk($sformatf("v%0d_mem_ce", i), 32'(mem_ce),
          32'(vt[i].e_if_gnt | vt[i].e_lpm_gnt));
      chk($sformatf("v%0d_mem_a", i), 32'(mem_a), 32'(vt[i].e_mem_a));
      chk($sformatf("v%0d_if_valid", i), 32'(if_valid),
          32'(vt[i].e_if_valid));
      chk($sformatf("v%0d_lpm_valid", i), 32'(lpm_valid),
          32'(vt[i].e_lpm_valid));
      if (vt[i].e_if_valid)
        chk($sformatf("v%0d_if_d", i), 32'(if_d), 32'(vt[i].e_if_d));
      if (vt[i].e_lpm_valid)
        chk($sformatf("v%0d_lpm_d", i), 32'(lpm_d), 32'(vt[i].e_lpm_d));
      @(posedge clk); #1;
    end

    // Starvation: both held; limit 4 -> FFFFL, limit 1 -> FLFL
    pif = 1'b0; plpm = 1'b0;
    if_req = 1'b1; if_a = 10'h040;
    lpm_req = 1'b1; lpm_a = 11'h0C1;
    for (int k = 0; k < 10; k++) begin
      el = (k % 5 == 4);
      el1 = (k % 2 == 1);
      @(negedge clk);
      chk($sformatf("st%0d_if_gnt", k), 32'(if_gnt), 32'(!el));
      chk($sformatf("st%0d_lpm_gnt", k), 32'(lpm_gnt), 32'(el));
      chk($sformatf("st%0d_mem_a", k), 32'(mem_a),
          el ? 32'h060 : 32'h040);
      chk($sformatf("st%0d_if_valid", k), 32'(if_valid), 32'(pif));
      chk($sformatf("st%0d_lpm_valid", k), 32'(lpm_valid), 32'(plpm));
      if (pif) chk($sformatf("st%0d_if_d", k), 32'(if_d), 32'h5040);
      if (plpm) chk($sformatf("st%0d_lpm_d", k), 32'(lpm_d), 32'h50);
      chk($sformatf("st1_%0d_lpm_gnt", k), 32'(lpm_gnt1), 32'(el1));
      chk($sformatf("st1_%0d_if_gnt", k), 32'(if_gnt1), 32'(!el1));
      pif = !el; plpm = el;
      @(posedge clk); #1;
    end
    if_req = 1'b0; lpm_req = 1'b0;
    @(negedge clk);
    chk("st_tail_lpm_valid", 32'(lpm_valid), 1);
    chk("st_tail_lpm_d", 32'(lpm_d), 32'h50);
    chk("st_tail_if_valid", 32'(if_valid), 0);
    @(posedge clk); #1;

    // Fetch stream with an LPM request deferred until the bound
    fa = 10'h010; pif = 1'b0; plpm = 1'b0; pa = '0;
    lpm_a = 11'h0E0;
    for (int c = 0; c < 10; c++) begin
      if_req = 1'b1; if_a = fa;
      lpm_req = (c >= 1 && c <= 5);
      @(negedge clk);
      chk($sformatf("bb%0d_mem_ce", c), 32'(mem_ce), 1);
      chk($sformatf("bb%0d_if_gnt", c), 32'(if_gnt), 32'(c != 5));
      chk($sformatf("bb%0d_lpm_gnt", c), 32'(lpm_gnt), 32'(c == 5));
      chk($sformatf("bb%0d_mem_a", c), 32'(mem_a),
          (c == 5) ? 32'h070 : 32'(fa));
      chk($sformatf("bb%0d_if_valid", c), 32'(if_valid), 32'(pif));
      chk($sformatf("bb%0d_lpm_valid", c), 32'(lpm_valid), 32'(plpm));
      if (pif) chk($sformatf("bb%0d_if_d", c), 32'(if_d), 32'(mem[pa]));
      if (plpm) chk($sformatf("bb%0d_lpm_d", c), 32'(lpm_d), 32'h70);
      pif = (c != 5); plpm = (c == 5); pa = fa;
      if (c != 5) fa = fa + 10'd1;
      @(posedge clk); #1;
    end
    if_req = 1'b0; lpm_req = 1'b0;
    @(negedge clk);
    chk("bb_tail_if_valid", 32'(if_valid), 1);
    chk("bb_tail_if_d", 32'(if_d), 32'(mem[pa]));
    @(posedge clk); #1;

    // Withdrawn LPM request, then counter must restart from zero
    for (int w = 0; w < 9; w++) begin
      if_req = 1'b1; if_a = 10'h200;
      lpm_req = (w == 1 || w == 2 || w >= 4);
      lpm_a = (w < 3) ? 11'h003 : 11'h0C1;
      @(negedge clk);
      chk($sformatf("wd%0d_lpm_gnt", w), 32'(lpm_gnt), 32'(w == 8));
      chk($sformatf("wd%0d_if_gnt", w), 32'(if_gnt), 32'(w != 8));
      chk($sformatf("wd%0d_lpm_valid", w), 32'(lpm_valid), 0);
      @(posedge clk); #1;
    end
    if_req = 1'b0; lpm_req = 1'b0;
    @(negedge clk);
    chk("wd_tail_lpm_valid", 32'(lpm_valid), 1);
    chk("wd_tail_lpm_d", 32'(lpm_d), 32'h50);
    @(posedge clk); #1;

    // Reset pulse while a fetch is in flight
    if_req = 1'b1; if_a = 10'h005;
    @(negedge clk);
    chk("rr_if_gnt", 32'(if_gnt), 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rr_if_valid_in_rst", 32'(if_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_if_valid_after", 32'(if_valid), 0);
    chk("rr_lpm_valid_after", 32'(lpm_valid), 0);
    chk("rr_mem_ce_idle", 32'(mem_ce), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
